inv_key_schedule_seq: RTL and testbench

- Sequential AES-128 inverse key expander for the decryption datapath.
- Accepts the last round key (round 10) and walks the key schedule backwards one round per accepted output, down to round 0 (the cipher key).
- Emits each round key through a valid/ready handshake, so the inverse-cipher rounds consume keys on the fly with no 11-entry key store.
- It is the counterpart of the forward per-round key schedule block and uses the same 128-bit key-bus byte layout.

---
 rtl/aes_pkg.sv | 33 +++
 rtl/inv_key_schedule_seq_if.sv | 36 +++
 rtl/inv_key_round.sv | 33 +++
 rtl/sbox.sv | 18 +
 rtl/inv_key_schedule_seq.sv | 95 +++++++++
 tb/tb_inv_key_schedule_seq.sv | 184 ++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, FSM state type and key-bus layout helpers.
// Key bus: byte(row r, col c) at bits [32r+8(3-c) +: 8]; column words carry row 0 in the MSB byte.
package aes_pkg;

  localparam int         AES_NR    = 10;
  localparam logic [7:0] RCON_LAST = 8'h36;
  localparam logic [7:0] AES_POLY  = 8'h1B;

  typedef enum logic {IDLE, OUT} ks_state_e;

  function automatic int byte_lsb(input int r, input int c);
    return 32 * r + 8 * (3 - c);
  endfunction

  function automatic logic [31:0] col_word(input logic [127:0] key, input int c);
    logic [31:0] w;
    for (int r = 0; r < 4; r++) w[8*(3-r) +: 8] = key[byte_lsb(r, c) +: 8];
    return w;
  endfunction

  function automatic logic [127:0] pack_cols(input logic [3:0][31:0] w);
    logic [127:0] key;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) key[byte_lsb(r, c) +: 8] = w[c][8*(3-r) +: 8];
    return key;
  endfunction

  // Inverse of xtime: steps the round constant backwards (36 -> 1B -> 80 -> ... -> 01).
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? (((x ^ AES_POLY) >> 1) | 8'h80) : (x >> 1);
  endfunction

endpackage

// File: rtl/inv_key_schedule_seq_if.sv
// Load / round-key handshake bundle for inv_key_schedule_seq.
// INV_KS_KEY_CHECK_EN adds Key_Expected / Key_Match for the final-key comparison.
interface inv_key_schedule_seq_if #(
  parameter int BUS_WIDTH = 128
);
  logic                 Start;
  logic [BUS_WIDTH-1:0] Key_Last;
  logic                 Ready;
  logic [BUS_WIDTH-1:0] Round_Key;
  logic                 Round_Key_Valid;
  logic                 Round_Key_Ready;
  logic [3:0]           Round_Num;
  logic                 Done;
`ifdef INV_KS_KEY_CHECK_EN
  logic [BUS_WIDTH-1:0] Key_Expected;
  logic                 Key_Match;

  modport master (
    output Start, Key_Last, Round_Key_Ready, Key_Expected,
    input  Ready, Round_Key, Round_Key_Valid, Round_Num, Done, Key_Match
  );
  modport slave (
    input  Start, Key_Last, Round_Key_Ready, Key_Expected,
    output Ready, Round_Key, Round_Key_Valid, Round_Num, Done, Key_Match
  );
`else
  modport master (
    output Start, Key_Last, Round_Key_Ready,
    input  Ready, Round_Key, Round_Key_Valid, Round_Num, Done
  );
  modport slave (
    input  Start, Key_Last, Round_Key_Ready,
    output Ready, Round_Key, Round_Key_Valid, Round_Num, Done
  );
`endif
endinterface

// File: rtl/inv_key_round.sv
// One backward step of the AES-128 key schedule: round-r key + rcon -> round-(r-1) key.
module inv_key_round
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] rot, sub;

  assign w0 = col_word(key_i, 0);
  assign w1 = col_word(key_i, 1);
  assign w2 = col_word(key_i, 2);
  assign w3 = col_word(key_i, 3);

  // Columns 1..3 undo the forward XOR chain; column 0 needs the recovered previous w3.
  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = {p3[23:0], p3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sbox u_sbox (
      .data (rot[8*i +: 8]),
      .dout (sub[8*i +: 8])
    );
  end

  assign p0    = w0 ^ sub ^ {rcon_i, 24'h0};
  assign key_o = pack_cols({p3, p2, p1, p0});
endmodule

// File: rtl/sbox.sv
// Forward AES S-box cell (combinational table lookup).
module sbox (
  input  logic [7:0] data,
  output logic [7:0] dout
);
  localparam logic [0:255][7:0] SBOX_LUT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX_LUT[data];
endmodule

// File: rtl/inv_key_schedule_seq.sv
// Sequential AES-128 inverse key expander: emits round keys 10 down to 0 over a valid/ready handshake.
// Optional INV_KS_KEY_CHECK_EN compares the recovered cipher key against Key_Expected.
module inv_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int BUS_WIDTH  = 128,
  parameter int NUM_ROUNDS = AES_NR
) (
  input logic                   Clk,
  input logic                   Rst,
  inv_key_schedule_seq_if.slave ks
);
  ks_state_e            state_q, state_d;
  logic [BUS_WIDTH-1:0] key_q, key_d, key_prev;
  logic [3:0]           round_q, round_d;
  logic [7:0]           rcon_q, rcon_d;
  logic                 done_q, done_d;

  inv_key_round u_inv_key_round (
    .key_i  (key_q),
    .rcon_i (rcon_q),
    .key_o  (key_prev)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path leaves one unassigned (no latches).
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (ks.Start) begin
        state_d = OUT;
        key_d   = ks.Key_Last;
        round_d = 4'(NUM_ROUNDS);
        rcon_d  = RCON_LAST;
      end
      OUT: if (ks.Round_Key_Ready) begin
        if (round_q != '0) begin
          key_d   = key_prev;
          round_d = round_q - 4'd1;
          rcon_d  = inv_xtime(rcon_q);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so all registers see pre-edge values of each other.
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign ks.Ready           = (state_q == IDLE);
  assign ks.Round_Key_Valid = (state_q == OUT);
  assign ks.Round_Key       = key_q;
  assign ks.Round_Num       = round_q;
  assign ks.Done            = done_q;

`ifdef INV_KS_KEY_CHECK_EN
  logic match_q, match_d;

  // Result latches on the round-0 handshake and is cleared when the next run is accepted.
  always_comb begin
    match_d = match_q;
    if (state_q == IDLE && ks.Start)
      match_d = 1'b0;
    else if (state_q == OUT && ks.Round_Key_Ready && round_q == '0)
      match_d = (key_q == ks.Key_Expected);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) match_q <= 1'b0;
    else      match_q <= match_d;
  end

  assign ks.Key_Match = match_q;
`endif
endmodule

// File: tb/tb_inv_key_schedule_seq.sv
// Directed bench for inv_key_schedule_seq using FIPS-197 and all-zero key vectors.
module tb_inv_key_schedule_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inv_key_schedule_seq_if #(.BUS_WIDTH(128)) ks_if ();

  inv_key_schedule_seq dut (
    .Clk (clk),
    .Rst (rst_n),
    .ks  (ks_if.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] got_key [0:15];
  int done_cyc;
  int n_acc;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [31:0] w0, w1, w2, w3);
    logic [31:0]  w [4];
    logic [127:0] k;
    w = '{w0, w1, w2, w3};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) k[32*r + 8*(3-c) +: 8] = w[c][31-8*r -: 8];
    return k;
  endfunction

  task automatic start_run(input logic [127:0] key);
    @(negedge clk);
    ks_if.Start    = 1'b1;
    ks_if.Key_Last = key;
    @(negedge clk);
    ks_if.Start    = 1'b0;
  endtask

  // Consumes keys from the first post-Start sample; toggle applies the 1,0,0,1 ready pattern.
  task automatic drain(input bit toggle, input bit inject, input logic [127:0] inj_key);
    logic [127:0] prev_key = '0;
    logic [3:0]   prev_num = '0;
    bit           prev_stall = 1'b0;
    bit           rdy;
    done_cyc = 0;
    n_acc    = 0;
    for (int i = 0; i < 16; i++) got_key[i] = 'x;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (ks_if.Done) begin
        done_cyc = cyc;
        check("done_valid_low", {127'd0, ks_if.Round_Key_Valid}, 128'd0);
        break;
      end
      if (prev_stall) begin
        check("stall_key", ks_if.Round_Key, prev_key);
        check("stall_num", {124'd0, ks_if.Round_Num}, {124'd0, prev_num});
      end
      rdy = toggle ? (cyc % 4 == 1 || cyc % 4 == 0) : 1'b1;
      ks_if.Round_Key_Ready = rdy;
      ks_if.Start = inject && (cyc == 3);
      if (inject && cyc == 3) ks_if.Key_Last = inj_key;
      if (ks_if.Round_Key_Valid && rdy) begin
        check("num_order", {124'd0, ks_if.Round_Num}, 128'(10 - n_acc));
        got_key[ks_if.Round_Num] = ks_if.Round_Key;
        n_acc++;
      end
      prev_stall = ks_if.Round_Key_Valid && !rdy;
      prev_key   = ks_if.Round_Key;
      prev_num   = ks_if.Round_Num;
      @(negedge clk);
    end
    ks_if.Start = 1'b0;
    if (done_cyc == 0) check("done_timeout", 128'd0, 128'd1);
  endtask

  logic [127:0] k10, k9, k0, z9, z8;

  initial begin
    k10 = pack(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6);
    k9  = pack(32'hac7766f3, 32'h19fadc21, 32'h28d12941, 32'h575c006e);
    k0  = pack(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
    z9  = pack(32'h55636363, 32'h0, 32'h0, 32'h0);
    z8  = pack(32'h2d000000, 32'h55636363, 32'h0, 32'h0);

    rst_n = 1'b0;
    ks_if.Start = 1'b0;
    ks_if.Key_Last = '0;
    ks_if.Round_Key_Ready = 1'b0;
`ifdef INV_KS_KEY_CHECK_EN
    ks_if.Key_Expected = k0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ready", {127'd0, ks_if.Ready}, 128'd1);
    check("rst_valid", {127'd0, ks_if.Round_Key_Valid}, 128'd0);
    check("rst_done", {127'd0, ks_if.Done}, 128'd0);
    check("rst_key", ks_if.Round_Key, 128'd0);
    check("rst_num", {124'd0, ks_if.Round_Num}, 128'd0);
`ifdef INV_KS_KEY_CHECK_EN
    check("rst_match", {127'd0, ks_if.Key_Match}, 128'd0);
`endif
    rst_n = 1'b1;

    ks_if.Round_Key_Ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_rkr_valid", {127'd0, ks_if.Round_Key_Valid}, 128'd0);
    check("idle_rkr_ready", {127'd0, ks_if.Ready}, 128'd1);

    // FIPS-197 key, consumer always ready
    start_run(k10);
    drain(1'b0, 1'b0, '0);
    check("t1_r10", got_key[10], k10);
    check("t1_r9", got_key[9], k9);
    check("t1_r0", got_key[0], k0);
    check("t1_done_cycle", 128'(done_cyc), 128'd12);
    check("t1_accepts", 128'(n_acc), 128'd11);
`ifdef INV_KS_KEY_CHECK_EN
    check("t1_match", {127'd0, ks_if.Key_Match}, 128'd1);
`endif
    @(negedge clk);
    check("t1_done_pulse", {127'd0, ks_if.Done}, 128'd0);

    // Stalling consumer
    start_run(k10);
`ifdef INV_KS_KEY_CHECK_EN
    check("t2_match_clear", {127'd0, ks_if.Key_Match}, 128'd0);
`endif
    drain(1'b1, 1'b0, '0);
    check("t2_r10", got_key[10], k10);
    check("t2_r9", got_key[9], k9);
    check("t2_r0", got_key[0], k0);
    check("t2_accepts", 128'(n_acc), 128'd11);

    // Start during OUT must be ignored
    start_run(k10);
    drain(1'b0, 1'b1, ~k10);
    check("t3_r10", got_key[10], k10);
    check("t3_r0", got_key[0], k0);
    check("t3_done_cycle", 128'(done_cyc), 128'd12);

    // Reset mid-run at round 5
    start_run(k10);
    ks_if.Round_Key_Ready = 1'b1;
    for (int n = 0; n < 20 && ks_if.Round_Num != 4'd5; n++) @(negedge clk);
    check("t4_reach_r5", {124'd0, ks_if.Round_Num}, 128'd5);
    rst_n = 1'b0;
    #1;
    check("t4_valid", {127'd0, ks_if.Round_Key_Valid}, 128'd0);
    check("t4_ready", {127'd0, ks_if.Ready}, 128'd1);
    check("t4_num", {124'd0, ks_if.Round_Num}, 128'd0);
    check("t4_key", ks_if.Round_Key, 128'd0);
    repeat (2) @(negedge clk);
    check("t4_no_done", {127'd0, ks_if.Done}, 128'd0);
    rst_n = 1'b1;
`ifdef INV_KS_KEY_CHECK_EN
    ks_if.Key_Expected = '0;
`endif
    start_run(k10);
    drain(1'b0, 1'b0, '0);
    check("t4_rerun_r0", got_key[0], k0);
    check("t4_rerun_done", 128'(done_cyc), 128'd12);
`ifdef INV_KS_KEY_CHECK_EN
    check("t6_nomatch", {127'd0, ks_if.Key_Match}, 128'd0);
`endif

    // Back-to-back zero-key run, Start in the cycle after Done
    start_run('0);
    drain(1'b0, 1'b0, '0);
    check("t5_r10", got_key[10], 128'd0);
    check("t5_r9", got_key[9], z9);
    check("t5_r8", got_key[8], z8);
    check("t5_accepts", 128'(n_acc), 128'd11);
    check("t5_done_cycle", 128'(done_cyc), 128'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
